pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_fwd_select.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and multicycle-FSM state codes.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Forwarding mux select for one EX-stage operand; the younger EX/MEM
// result takes precedence over MEM/WB.
module fwd_select
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_valid,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == src))
      sel = FWD_EXMEM;
    else if (wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == src))
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stalls, multicycle EX
// stalls, taken-branch flushes, operand forwarding and stall statistics.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_memread,
  input  logic              ex_is_mc,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              bubble,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [3:0]        stage_valid,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int            CW        = $clog2(MC_LAT + 1);
  localparam logic [CW-1:0] CNT_START = CW'(MC_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CNT_W-1:0] STALL_INC = CNT_W'(1);

  mc_state_t     state;
  logic [CW-1:0] cnt;
  logic [3:0]    sv;
  logic          br;
  logic          start;
  logic          mc_stall;
  logic          lu;

  assign br       = branch_taken & sv[2];
  assign start    = (state == MC_IDLE) & sv[1] & ex_is_mc & ~br;
  assign mc_stall = start | ((state == MC_BUSY) & (cnt != CNT_ONE));
  assign lu       = sv[0] & sv[1] & ex_memread & (ex_rt != '0) &
                    ((id_uses_rs & (ex_rt == id_rs)) | (id_uses_rt & (ex_rt == id_rt)));

  assign stage_valid = sv;
  assign mc_busy     = (state == MC_BUSY);

  // Priority: branch flush, then multicycle freeze, then load-use bubble.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    bubble      = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (br) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (mc_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
    end
  end

  // A branch in MEM still retires into WB; everything younger is squashed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sv <= 4'b0000;
    else if (br)
      sv <= {sv[2], 3'b000};
    else if (mc_stall)
      sv <= {sv[2], 1'b0, sv[1:0]};
    else if (lu)
      sv <= {sv[2:1], 1'b0, sv[0]};
    else
      sv <= {sv[2:0], fetch_valid};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else if (br) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else if (start) begin
      state <= MC_BUSY;
      cnt   <= CNT_START;
    end else if (state == MC_BUSY) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE)
        state <= MC_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (!pc_write && (stall_cnt != '1))
      stall_cnt <= stall_cnt + STALL_INC;
  end

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src          (ex_rs),
    .mem_valid    (sv[2]),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_valid     (sv[3]),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .sel          (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src          (ex_rt),
    .mem_valid    (sv[2]),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_valid     (sv[3]),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .sel          (fwd_b)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: each cycle's stimulus
// queues its hand-computed expectation, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 3;

  typedef struct packed {
    logic              reset;
    logic              fv;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              urs;
    logic              urt;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic              memread;
    logic              is_mc;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              mem_rw;
    logic              wb_rw;
    logic              br;
  } stim_t;

  typedef struct packed {
    logic             pw;
    logic             ifw;
    logic             idw;
    logic             bub;
    logic [2:0]       fl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [3:0]       sv;
    logic             busy;
    logic [CNT_W-1:0] scnt;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              fetch_valid;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
  logic              id_uses_rs, id_uses_rt, ex_memread, ex_is_mc;
  logic              mem_regwrite, wb_regwrite, branch_taken;
  logic              pc_write, ifid_write, idex_write, bubble;
  logic              flush_ifid, flush_idex, flush_exmem;
  logic [1:0]        fwd_a, fwd_b;
  logic [3:0]        stage_valid;
  logic              mc_busy;
  logic [CNT_W-1:0]  stall_cnt;

  stim_t s;
  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (fetch_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_memread   (ex_memread),
    .ex_is_mc     (ex_is_mc),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_regwrite (mem_regwrite),
    .wb_regwrite  (wb_regwrite),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_write   (idex_write),
    .bubble       (bubble),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .flush_exmem  (flush_exmem),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stage_valid  (stage_valid),
    .mc_busy      (mc_busy),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mkexp(input logic pw, input logic ifw, input logic idw,
                                 input logic bub, input logic [2:0] fl,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [3:0] sv, input logic busy,
                                 input logic [CNT_W-1:0] scnt);
    exp_t e;
    e.pw = pw; e.ifw = ifw; e.idw = idw; e.bub = bub; e.fl = fl;
    e.fa = fa; e.fb = fb; e.sv = sv; e.busy = busy; e.scnt = scnt;
    return e;
  endfunction

  task automatic clearStim();
    s = '0;
    s.reset = 1'b1;
    s.fv    = 1'b1;
  endtask

  task automatic driveInputs();
    reset        = s.reset;
    fetch_valid  = s.fv;
    id_rs        = s.id_rs;
    id_rt        = s.id_rt;
    id_uses_rs   = s.urs;
    id_uses_rt   = s.urt;
    ex_rs        = s.ex_rs;
    ex_rt        = s.ex_rt;
    ex_memread   = s.memread;
    ex_is_mc     = s.is_mc;
    mem_rd       = s.mem_rd;
    wb_rd        = s.wb_rd;
    mem_regwrite = s.mem_rw;
    wb_regwrite  = s.wb_rw;
    branch_taken = s.br;
  endtask

  // Inputs change just after the rising edge; the expectation covers the
  // cycle that follows, up to the next rising edge.
  task automatic applyStimulus(input string name, input exp_t e);
    @(posedge clk);
    #1;
    driveInputs();
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic checkOutput(input string name, input string field,
                             input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s.%s got=%0h want=%0h", name, field, act, want);
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checkOutput(n, "pc_write",    {7'b0, pc_write},   {7'b0, e.pw});
        checkOutput(n, "ifid_write",  {7'b0, ifid_write}, {7'b0, e.ifw});
        checkOutput(n, "idex_write",  {7'b0, idex_write}, {7'b0, e.idw});
        checkOutput(n, "bubble",      {7'b0, bubble},     {7'b0, e.bub});
        checkOutput(n, "flush",       {5'b0, flush_exmem, flush_idex, flush_ifid}, {5'b0, e.fl});
        checkOutput(n, "fwd_a",       {6'b0, fwd_a},      {6'b0, e.fa});
        checkOutput(n, "fwd_b",       {6'b0, fwd_b},      {6'b0, e.fb});
        checkOutput(n, "stage_valid", {4'b0, stage_valid},{4'b0, e.sv});
        checkOutput(n, "mc_busy",     {7'b0, mc_busy},    {7'b0, e.busy});
        checkOutput(n, "stall_cnt",   {5'b0, stall_cnt},  {5'b0, e.scnt});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    clearStim();
    s.reset = 1'b0;
    driveInputs();

    // Reset state
    applyStimulus("R0", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0000,1'b0,3'd0));
    applyStimulus("R1", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0000,1'b0,3'd0));

    // Pipeline fill
    clearStim();
    applyStimulus("N1", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0000,1'b0,3'd0));
    applyStimulus("N2", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0001,1'b0,3'd0));
    applyStimulus("N3", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0011,1'b0,3'd0));
    applyStimulus("N4", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0111,1'b0,3'd0));

    // Load-use on r5: one bubble, then the load forwards from MEM/WB
    clearStim(); s.memread = 1'b1; s.ex_rt = 5'd5; s.id_rs = 5'd5; s.urs = 1'b1;
    applyStimulus("L1", mkexp(1'b0,1'b0,1'b1,1'b1,3'b000,2'b00,2'b00,4'b1111,1'b0,3'd0));
    clearStim(); s.mem_rd = 5'd5; s.mem_rw = 1'b1; s.id_rs = 5'd5; s.urs = 1'b1;
    applyStimulus("L2", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b1101,1'b0,3'd1));
    clearStim(); s.ex_rs = 5'd5; s.ex_rt = 5'd2; s.wb_rd = 5'd5; s.wb_rw = 1'b1;
    applyStimulus("L3", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b01,2'b00,4'b1011,1'b0,3'd1));

    // Forwarding priority and r0 / regwrite qualification
    clearStim(); s.mem_rd = 5'd3; s.mem_rw = 1'b1; s.wb_rd = 5'd3; s.wb_rw = 1'b1;
    s.ex_rs = 5'd3; s.ex_rt = 5'd3;
    applyStimulus("F1", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b10,2'b10,4'b0111,1'b0,3'd1));
    clearStim(); s.mem_rd = 5'd0; s.mem_rw = 1'b1; s.wb_rd = 5'd3; s.wb_rw = 1'b1;
    s.ex_rs = 5'd3; s.ex_rt = 5'd7;
    applyStimulus("F2", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b01,2'b00,4'b1111,1'b0,3'd1));
    clearStim(); s.mem_rd = 5'd3; s.mem_rw = 1'b0; s.wb_rd = 5'd3; s.wb_rw = 1'b1;
    s.ex_rs = 5'd4; s.ex_rt = 5'd3;
    applyStimulus("F3", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b01,4'b1111,1'b0,3'd1));

    // Multicycle op: three stall cycles, three busy cycles
    clearStim(); s.is_mc = 1'b1;
    applyStimulus("M0", mkexp(1'b0,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,4'b1111,1'b0,3'd1));
    applyStimulus("M1", mkexp(1'b0,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,4'b1011,1'b1,3'd2));
    applyStimulus("M2", mkexp(1'b0,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,4'b0011,1'b1,3'd3));
    applyStimulus("M3", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0011,1'b1,3'd4));
    clearStim();
    applyStimulus("M4", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0111,1'b0,3'd4));

    // Branch while EX/MEM is empty is ignored; branch with EX/MEM valid flushes
    clearStim(); s.is_mc = 1'b1;
    applyStimulus("B0", mkexp(1'b0,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,4'b1111,1'b0,3'd4));
    s.br = 1'b1;
    applyStimulus("B1", mkexp(1'b0,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,4'b1011,1'b1,3'd5));
    s.br = 1'b0;
    applyStimulus("B2", mkexp(1'b0,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,4'b0011,1'b1,3'd6));
    applyStimulus("B3", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0011,1'b1,3'd7));
    s.br = 1'b1;
    applyStimulus("B4", mkexp(1'b1,1'b1,1'b1,1'b0,3'b111,2'b00,2'b00,4'b0111,1'b0,3'd7));
    clearStim(); s.br = 1'b1;
    applyStimulus("B5", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b1000,1'b0,3'd7));
    clearStim();
    applyStimulus("B6", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0001,1'b0,3'd7));
    applyStimulus("B7", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0011,1'b0,3'd7));
    applyStimulus("B8", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0111,1'b0,3'd7));

    // Saturated stall counter, then reset aborts a busy op
    clearStim(); s.is_mc = 1'b1;
    applyStimulus("X0", mkexp(1'b0,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,4'b1111,1'b0,3'd7));
    applyStimulus("X1", mkexp(1'b0,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,4'b1011,1'b1,3'd7));
    s.reset = 1'b0;
    applyStimulus("X2", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0000,1'b0,3'd0));
    s.reset = 1'b1;
    applyStimulus("X3", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0000,1'b0,3'd0));
    clearStim();
    applyStimulus("X4", mkexp(1'b1,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,4'b0001,1'b0,3'd0));

    repeat (3) @(posedge clk);
    checkOutput("drain", "pending", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
